// File: rtl/word_align_checker.sv
// word_align_checker: pairs each ISERDES word with a delayed copy of the TX
// word, drives bitslip and a word-delay index until the stream locks, then
// counts and flags data errors.
// Optional build macro WORD_ALIGN_RELOCK_EN: four consecutive mismatches while
// locked drop back to search instead of LOCKED being terminal.
module word_align_checker #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned SLIPS_PER_WRAP = 16,
  parameter int unsigned SLIP_WAIT      = 4,
  parameter int unsigned LOCK_COUNT     = 16,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TX_STB,
  input  logic [WIDTH-1:0]     TX_DAT,
  input  logic                 RX_STB,
  input  logic [WIDTH-1:0]     RX_DAT,
  output logic                 O_BITSLIP,
  output logic                 O_LOCKED,
  output logic                 O_ERROR,
  output logic [ERR_CNT_W-1:0] O_ERR_CNT
);

  localparam int unsigned SLIP_CNT_W  = (SLIPS_PER_WRAP > 1) ? $clog2(SLIPS_PER_WRAP) : 1;
  localparam int unsigned MATCH_CNT_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WAIT_CNT_W  = $clog2(SLIP_WAIT + 1);
  localparam int unsigned EXH_SLIPS   = 4 * SLIPS_PER_WRAP;
  localparam int unsigned EXH_CNT_W   = $clog2(EXH_SLIPS + 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SLIP   = 2'd1,
    S_WAIT   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [SLIP_CNT_W-1:0]  slip_cnt_q,  slip_cnt_d;
  logic [1:0]             dly_idx_q,   dly_idx_d;
  logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
  logic [EXH_CNT_W-1:0]   exh_cnt_q,   exh_cnt_d;
  logic                   bitslip_q,   bitslip_d;
  logic                   locked_q,    locked_d;
  logic                   error_q,     error_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q,   err_cnt_d;
`ifdef WORD_ALIGN_RELOCK_EN
  logic [1:0]             mis_cnt_q,   mis_cnt_d;
`endif

  logic [WIDTH-1:0] hist_q [4];
  logic             match;

  // Compare against the pre-shift history selected by the delay index
  assign match = (RX_DAT == hist_q[dly_idx_q]);

  // TX history shift register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (TX_STB) begin
      hist_q[3] <= hist_q[2];
      hist_q[2] <= hist_q[1];
      hist_q[1] <= hist_q[0];
      hist_q[0] <= TX_DAT;
    end
  end

  // State and counter registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_SEARCH;
      slip_cnt_q  <= '0;
      dly_idx_q   <= '0;
      match_cnt_q <= '0;
      wait_cnt_q  <= '0;
      exh_cnt_q   <= '0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_cnt_q   <= '0;
`ifdef WORD_ALIGN_RELOCK_EN
      mis_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slip_cnt_q  <= slip_cnt_d;
      dly_idx_q   <= dly_idx_d;
      match_cnt_q <= match_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      exh_cnt_q   <= exh_cnt_d;
      bitslip_q   <= bitslip_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_cnt_q   <= err_cnt_d;
`ifdef WORD_ALIGN_RELOCK_EN
      mis_cnt_q   <= mis_cnt_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    slip_cnt_d  = slip_cnt_q;
    dly_idx_d   = dly_idx_q;
    match_cnt_d = match_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    exh_cnt_d   = exh_cnt_q;
    bitslip_d   = 1'b0;
    locked_d    = locked_q;
    error_d     = error_q;
    err_cnt_d   = err_cnt_q;
`ifdef WORD_ALIGN_RELOCK_EN
    mis_cnt_d   = mis_cnt_q;
`endif

    case (state_q)
      S_SEARCH: begin
        if (RX_STB) begin
          if (match) begin
            match_cnt_d = match_cnt_q + MATCH_CNT_W'(1);
            if (match_cnt_q == MATCH_CNT_W'(LOCK_COUNT - 1)) begin
              state_d   = S_LOCKED;
              locked_d  = 1'b1;
              exh_cnt_d = '0;
`ifdef WORD_ALIGN_RELOCK_EN
              mis_cnt_d = '0;
`endif
            end
          end else begin
            match_cnt_d = '0;
            bitslip_d   = 1'b1;
            state_d     = S_SLIP;
          end
        end
      end

      S_SLIP: begin
        if (slip_cnt_q == SLIP_CNT_W'(SLIPS_PER_WRAP - 1)) begin
          slip_cnt_d = '0;
          dly_idx_d  = dly_idx_q + 2'd1;
        end else begin
          slip_cnt_d = slip_cnt_q + SLIP_CNT_W'(1);
        end
        // Exhaustion: every slip/delay combination tried without locking
        if (exh_cnt_q != EXH_CNT_W'(EXH_SLIPS)) begin
          exh_cnt_d = exh_cnt_q + EXH_CNT_W'(1);
          if (exh_cnt_q == EXH_CNT_W'(EXH_SLIPS - 1)) error_d = 1'b1;
        end
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (RX_STB) begin
          if (wait_cnt_q == WAIT_CNT_W'(SLIP_WAIT - 1)) begin
            wait_cnt_d = '0;
            state_d    = S_SEARCH;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end
      end

      S_LOCKED: begin
        if (RX_STB) begin
          if (!match) begin
            error_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
`ifdef WORD_ALIGN_RELOCK_EN
            if (mis_cnt_q == 2'd3) begin
              mis_cnt_d   = '0;
              match_cnt_d = '0;
              locked_d    = 1'b0;
              state_d     = S_SEARCH;
            end else begin
              mis_cnt_d = mis_cnt_q + 2'd1;
            end
          end else begin
            mis_cnt_d = '0;
`endif
          end
        end
      end

      default: state_d = S_SEARCH;
    endcase
  end

  assign O_BITSLIP = bitslip_q;
  assign O_LOCKED  = locked_q;
  assign O_ERROR   = error_q;
  assign O_ERR_CNT = err_cnt_q;

endmodule
